// File: rtl/bcd_scan_ca_controller.sv
// Multiplexed scan controller for an N-digit common-anode 7-segment display with a shared decoder.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bcd_scan_ca_controller #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] BCD_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              Segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   SEL,
    output logic                    frame_done,
    output logic                    update_pending
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);
    localparam logic [CntW:0]   BlankLen = (CntW + 1)'(BLANK_CYCLES);

    typedef enum logic {StGuard, StDrive} slot_state_e;

    localparam slot_state_e StReset = (BLANK_CYCLES > 0) ? StGuard : StDrive;

    function automatic logic [6:0] decode_bcd(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    slot_state_e               state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   act_bcd_q, act_bcd_d;
    logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d;
    logic [4*NUM_DIGITS-1:0]   pend_bcd_q, pend_bcd_d;
    logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic                      pend_valid_q, pend_valid_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     sel_q, sel_d;
    logic                      frame_done_q, frame_done_d;

    logic                      slot_end;
    logic                      frame_end;
    logic [3:0]                cur_bcd;
    logic                      cur_dp;
    logic                      cur_lz;
    logic [NUM_DIGITS-1:0]     lz_blank;

    // Slot/digit sequencing and the double-buffer handoff.
    always_comb begin
        slot_end  = (cnt_q == CntLast);
        frame_end = slot_end && (idx_q == IdxLast);

        cnt_d = slot_end ? '0 : cnt_q + CntW'(1);
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
        end
        state_d = ({1'b0, cnt_d} < BlankLen) ? StGuard : StDrive;

        act_bcd_d    = act_bcd_q;
        act_dp_d     = act_dp_q;
        pend_bcd_d   = pend_bcd_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        if (frame_end) begin
            // A load on the boundary bypasses the pending buffer and drops older pending data.
            if (load) begin
                act_bcd_d    = BCD_in;
                act_dp_d     = dp_in;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                act_bcd_d    = pend_bcd_q;
                act_dp_d     = pend_dp_q;
                pend_valid_d = 1'b0;
            end
        end else if (load) begin
            pend_bcd_d   = BCD_in;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end
    end

    always_comb begin
        lz_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic zero_run;
            zero_run = 1'b1;
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                zero_run    = zero_run && (act_bcd_q[4*i +: 4] == 4'd0);
                lz_blank[i] = zero_run;
            end
        end
`endif
    end

    // Output values for the current (cnt, idx) state, registered below.
    always_comb begin
        cur_bcd = 4'd0;
        cur_dp  = 1'b1;
        cur_lz  = 1'b0;
        sel_d   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_bcd = act_bcd_q[4*i +: 4];
                cur_dp  = act_dp_q[i];
                cur_lz  = lz_blank[i];
                if (state_q == StDrive) begin
                    sel_d[i] = 1'b0;
                end
            end
        end

        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (state_q == StDrive) begin
            seg_d = cur_lz ? 7'b1111111 : decode_bcd(cur_bcd);
            dp_d  = cur_dp;
        end
        frame_done_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StReset;
            cnt_q        <= '0;
            idx_q        <= '0;
            act_bcd_q    <= '0;
            act_dp_q     <= '1;
            pend_bcd_q   <= '0;
            pend_dp_q    <= '1;
            pend_valid_q <= 1'b0;
            seg_q        <= 7'b1111111;
            dp_q         <= 1'b1;
            sel_q        <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_bcd_q    <= act_bcd_d;
            act_dp_q     <= act_dp_d;
            pend_bcd_q   <= pend_bcd_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign Segments       = seg_q;
    assign dp             = dp_q;
    assign SEL            = sel_q;
    assign frame_done     = frame_done_q;
    assign update_pending = pend_valid_q;

endmodule

// File: tb/tb_bcd_scan_ca_controller.sv
// Self-checking bench for bcd_scan_ca_controller (4 digits, 8-cycle slots, 2 guard cycles).
module tb_bcd_scan_ca_controller;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [6:0]  Segments;
    logic        dp;
    logic [3:0]  SEL;
    logic        frame_done;
    logic        update_pending;

    bcd_scan_ca_controller #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .BCD_in        (bcd_in),
        .dp_in         (dp_in),
        .Segments      (Segments),
        .dp            (dp),
        .SEL           (SEL),
        .frame_done    (frame_done),
        .update_pending(update_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       up;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          k;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_act_dp, m_pend_dp;
    logic        m_pv;
    logic        ld;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic lz_blank(input logic [15:0] a, input int di);
`ifdef LEADING_ZERO_BLANK_EN
        if (di == 0) return 1'b0;
        for (int j = di; j < N; j++) begin
            if (a[4*j +: 4] != 4'd0) return 1'b0;
        end
        return 1'b1;
`else
        return (a[0] & 1'b0) | (di < 0);
`endif
    endfunction

    task automatic model_reset();
        k         = 0;
        m_act     = 16'h0000;
        m_act_dp  = 4'hF;
        m_pend    = 16'h0000;
        m_pend_dp = 4'hF;
        m_pv      = 1'b0;
        sb_q.delete();
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the coming edge.
    task automatic drive_cycle(input logic l, input logic [15:0] b, input logic [3:0] d);
        exp_t x;
        int   pos, di;
        pos    = k % RD;
        di     = (k / RD) % N;
        load   = l;
        bcd_in = b;
        dp_in  = d;
        if (pos < BL) begin
            x.sel = 4'hF;
            x.seg = 7'h7F;
            x.dp  = 1'b1;
        end else begin
            x.sel = ~(4'b0001 << di);
            x.seg = lz_blank(m_act, di) ? 7'h7F : seg_of(m_act[4*di +: 4]);
            x.dp  = m_act_dp[di];
        end
        x.fd = (pos == RD - 1) && (di == N - 1);
        if (x.fd) begin
            if (l) begin
                m_act = b; m_act_dp = d; m_pv = 1'b0;
            end else if (m_pv) begin
                m_act = m_pend; m_act_dp = m_pend_dp; m_pv = 1'b0;
            end
        end else if (l) begin
            m_pend = b; m_pend_dp = d; m_pv = 1'b1;
        end
        x.up = m_pv;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        k++;
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        load   = 1'b0;
        bcd_in = 16'hDEAD;
        dp_in  = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (SEL !== 4'hF) begin
            errors++; $display("FAIL reset_sel got=%b exp=1111", SEL);
        end
        checks++;
        if (Segments !== 7'h7F || dp !== 1'b1) begin
            errors++; $display("FAIL reset_seg got=%b/%b exp=1111111/1", Segments, dp);
        end
        checks++;
        if (frame_done !== 1'b0 || update_pending !== 1'b0) begin
            errors++; $display("FAIL reset_flags got fd=%b up=%b exp=0/0", frame_done, update_pending);
        end
        reset = 1'b0;
        model_reset();
        while (k < 16) begin
            drive_cycle(1'b0, 16'hDEAD, 4'hF);
            e = sb_q.pop_front();
            checks++;
            if ({SEL, Segments, dp, frame_done, update_pending} !== e) begin
                errors++;
                $display("FAIL reset_scan k=%0d got=%b exp=%b", k,
                         {SEL, Segments, dp, frame_done, update_pending}, e);
            end
            if (k == 2 || k == 3 || k == 9 || k == 11) begin
                checks++;
                if ((k == 2 && SEL !== 4'b1111) || (k == 9 && SEL !== 4'b1111) ||
                    (k == 3 && (SEL !== 4'b1110 || Segments !== 7'b1000000)) ||
                    (k == 11 && SEL !== 4'b1101)) begin
                    errors++; $display("FAIL reset_plan k=%0d got sel=%b seg=%b", k, SEL, Segments);
                end
            end
        end
    endtask

    task automatic test_load();
        while (k < 96) begin
            ld = (k == 40);
            drive_cycle(ld, ld ? 16'h1234 : 16'hDEAD, ld ? 4'b1011 : 4'hF);
            e = sb_q.pop_front();
            checks++;
            if ({SEL, Segments, dp, frame_done, update_pending} !== e) begin
                errors++;
                $display("FAIL load k=%0d got=%b exp=%b", k,
                         {SEL, Segments, dp, frame_done, update_pending}, e);
            end
            if (k == 63 || k == 64 || k == 69 || k == 77 || k == 85 || k == 93) begin
                checks++;
                if ((k == 63 && update_pending !== 1'b1) ||
                    (k == 64 && (update_pending !== 1'b0 || frame_done !== 1'b1)) ||
                    (k == 69 && (SEL !== 4'b1110 || Segments !== 7'b0011001 || dp !== 1'b1)) ||
                    (k == 77 && (SEL !== 4'b1101 || Segments !== 7'b0110000)) ||
                    (k == 85 && (SEL !== 4'b1011 || Segments !== 7'b0100100 || dp !== 1'b0)) ||
                    (k == 93 && (SEL !== 4'b0111 || Segments !== 7'b1111001))) begin
                    errors++;
                    $display("FAIL load_plan k=%0d got sel=%b seg=%b dp=%b fd=%b up=%b", k, SEL,
                             Segments, dp, frame_done, update_pending);
                end
            end
        end
    endtask

    task automatic test_two_loads();
        while (k < 160) begin
            ld = (k == 100) || (k == 110);
            drive_cycle(ld, (k == 100) ? 16'h1111 : ((k == 110) ? 16'h5678 : 16'hDEAD), 4'hF);
            e = sb_q.pop_front();
            checks++;
            if ({SEL, Segments, dp, frame_done, update_pending} !== e) begin
                errors++;
                $display("FAIL two_loads k=%0d got=%b exp=%b", k,
                         {SEL, Segments, dp, frame_done, update_pending}, e);
            end
            if (k > 128) begin
                checks++;
                if (Segments === 7'b1111001 || (k == 133 && Segments !== 7'b0000000)) begin
                    errors++; $display("FAIL two_loads_win k=%0d got seg=%b", k, Segments);
                end
            end
        end
    endtask

    task automatic test_boundary_load();
        while (k < 224) begin
            ld = (k == 170) || (k == 191);
            drive_cycle(ld, (k == 170) ? 16'h4444 : ((k == 191) ? 16'h0987 : 16'hDEAD),
                        (k == 191) ? 4'b1110 : 4'hF);
            e = sb_q.pop_front();
            checks++;
            if ({SEL, Segments, dp, frame_done, update_pending} !== e) begin
                errors++;
                $display("FAIL boundary k=%0d got=%b exp=%b", k,
                         {SEL, Segments, dp, frame_done, update_pending}, e);
            end
            if (k == 190 || k == 192 || k == 197) begin
                checks++;
                if ((k == 190 && update_pending !== 1'b1) ||
                    (k == 192 && (update_pending !== 1'b0 || frame_done !== 1'b1)) ||
                    (k == 197 && (Segments !== 7'b1111000 || dp !== 1'b0))) begin
                    errors++;
                    $display("FAIL boundary_plan k=%0d got seg=%b dp=%b fd=%b up=%b", k, Segments,
                             dp, frame_done, update_pending);
                end
            end
        end
    endtask

    task automatic test_blank_code();
        while (k < 288) begin
            ld = (k == 230);
            drive_cycle(ld, ld ? 16'h1B23 : 16'hDEAD, 4'hF);
            e = sb_q.pop_front();
            checks++;
            if ({SEL, Segments, dp, frame_done, update_pending} !== e) begin
                errors++;
                $display("FAIL blank_code k=%0d got=%b exp=%b", k,
                         {SEL, Segments, dp, frame_done, update_pending}, e);
            end
            if (k == 277) begin
                checks++;
                if (SEL !== 4'b1011 || Segments !== 7'b1111111) begin
                    errors++; $display("FAIL blank_code_plan got sel=%b seg=%b exp=1011/1111111",
                                       SEL, Segments);
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] hi_seg;
`ifdef LEADING_ZERO_BLANK_EN
        hi_seg = 7'b1111111;
`else
        hi_seg = 7'b1000000;
`endif
        while (k < 352) begin
            ld = (k == 290);
            drive_cycle(ld, ld ? 16'h0045 : 16'hDEAD, 4'hF);
            e = sb_q.pop_front();
            checks++;
            if ({SEL, Segments, dp, frame_done, update_pending} !== e) begin
                errors++;
                $display("FAIL leading_zero k=%0d got=%b exp=%b", k,
                         {SEL, Segments, dp, frame_done, update_pending}, e);
            end
            if (k == 325 || k == 333 || k == 341 || k == 349) begin
                checks++;
                if ((k == 325 && Segments !== 7'b0010010) ||
                    (k == 333 && Segments !== 7'b0011001) ||
                    ((k == 341 || k == 349) && (Segments !== hi_seg || dp !== 1'b1))) begin
                    errors++; $display("FAIL leading_zero_plan k=%0d got seg=%b", k, Segments);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        while (k < 372) begin
            ld = (k == 360);
            drive_cycle(ld, ld ? 16'h9999 : 16'hDEAD, 4'hF);
            e = sb_q.pop_front();
            checks++;
            if ({SEL, Segments, dp, frame_done, update_pending} !== e) begin
                errors++;
                $display("FAIL reset_mid_pre k=%0d got=%b exp=%b", k,
                         {SEL, Segments, dp, frame_done, update_pending}, e);
            end
        end
        checks++;
        if (SEL !== 4'b1011) begin
            errors++; $display("FAIL reset_mid_digit2 got sel=%b exp=1011", SEL);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (SEL !== 4'hF || Segments !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0 ||
            update_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_blank got sel=%b seg=%b dp=%b fd=%b up=%b", SEL, Segments, dp,
                     frame_done, update_pending);
        end
        model_reset();
        while (k < 40) begin
            drive_cycle(1'b0, 16'hDEAD, 4'hF);
            e = sb_q.pop_front();
            checks++;
            if ({SEL, Segments, dp, frame_done, update_pending} !== e) begin
                errors++;
                $display("FAIL reset_mid_post k=%0d got=%b exp=%b", k,
                         {SEL, Segments, dp, frame_done, update_pending}, e);
            end
            if (k == 3) begin
                checks++;
                if (SEL !== 4'b1110 || Segments !== 7'b1000000) begin
                    errors++; $display("FAIL reset_mid_restart got sel=%b seg=%b", SEL, Segments);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_two_loads();
        test_boundary_load();
        test_blank_code();
        test_leading_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
